// File: rtl/dmem_pkg.sv
// Shared constants, response-state encoding and the address range helper
// for the DataMemory arbiter.
package dmem_pkg;

  localparam int          DEF_ADDR_W       = 32;
  localparam int          DEF_DATA_W       = 32;
  localparam int unsigned DEF_DEPTH        = 256;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  localparam int PORT_CORE = 0;
  localparam int PORT_LOAD = 1;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_CORE,
    RSP_LOAD
  } rsp_state_e;

  function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned depth);
    return addr < 64'(depth);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant picker: core wins ties unless the loader has hit its
// starvation limit.
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic       c_valid_i,
  input  logic       l_valid_i,
  input  logic       starve_hit_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o            = '0;
    grant_o[PORT_CORE] = c_valid_i & ~(l_valid_i & starve_hit_i);
    grant_o[PORT_LOAD] = l_valid_i & (~c_valid_i | starve_hit_i);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port DataMemory: core LSU has
// priority, loader/DMA is protected from starvation by a saturating counter.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int          ADDR_W       = DEF_ADDR_W,
  parameter int          DATA_W       = DEF_DATA_W,
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req_valid_i,
  output logic              c_req_ready_o,
  input  logic              c_req_we_i,
  input  logic [ADDR_W-1:0] c_req_addr_i,
  input  logic [DATA_W-1:0] c_req_wdata_i,
  output logic              c_rsp_valid_o,
  output logic [DATA_W-1:0] c_rsp_rdata_o,
  output logic              c_rsp_err_o,
  input  logic              l_req_valid_i,
  output logic              l_req_ready_o,
  input  logic              l_req_we_i,
  input  logic [ADDR_W-1:0] l_req_addr_i,
  input  logic [DATA_W-1:0] l_req_wdata_i,
  output logic              l_rsp_valid_o,
  output logic [DATA_W-1:0] l_rsp_rdata_o,
  output logic              l_rsp_err_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  output logic              mem_write_enable_o,
  output logic              mem_read_enable_o,
  input  logic [DATA_W-1:0] mem_read_data_i
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  rsp_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starveCnt_q, starveCnt_d;
  logic [DATA_W-1:0] rspRdata_q, rspRdata_d;
  logic              rspErr_q, rspErr_d;

  logic [1:0]        pickGnt;
  logic              cGnt, lGnt, anyGnt;
  logic              selWe, selInRange;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  dmem_arb_pick uPick (
    .c_valid_i    (c_req_valid_i),
    .l_valid_i    (l_req_valid_i),
    .starve_hit_i (starveCnt_q == CNT_MAX),
    .grant_o      (pickGnt)
  );

  // Grants are suppressed while reset is held so nothing handshakes or touches memory.
  assign cGnt   = pickGnt[PORT_CORE] & rst_n;
  assign lGnt   = pickGnt[PORT_LOAD] & rst_n;
  assign anyGnt = cGnt | lGnt;

  assign c_req_ready_o = cGnt;
  assign l_req_ready_o = lGnt;

  always_comb begin
    selWe    = 1'b0;
    selAddr  = '0;
    selWdata = '0;
    if (lGnt) begin
      selWe    = l_req_we_i;
      selAddr  = l_req_addr_i;
      selWdata = l_req_wdata_i;
    end else if (cGnt) begin
      selWe    = c_req_we_i;
      selAddr  = c_req_addr_i;
      selWdata = c_req_wdata_i;
    end
    selInRange = addr_in_range(64'(selAddr), DEPTH);
  end

  assign mem_address_o      = selAddr;
  assign mem_write_data_o   = selWdata;
  assign mem_write_enable_o = anyGnt & selWe & selInRange;
  assign mem_read_enable_o  = anyGnt & ~selWe & selInRange;

  always_comb begin
    state_d     = RSP_IDLE;
    rspRdata_d  = '0;
    rspErr_d    = 1'b0;
    starveCnt_d = '0;
    if (cGnt) begin
      state_d = RSP_CORE;
    end else if (lGnt) begin
      state_d = RSP_LOAD;
    end
    if (anyGnt) begin
      if (!selInRange) begin
        rspErr_d = 1'b1;
      end else if (!selWe) begin
        rspRdata_d = mem_read_data_i;
      end
    end
    if (cGnt && l_req_valid_i) begin
      starveCnt_d = (starveCnt_q == CNT_MAX) ? starveCnt_q : starveCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RSP_IDLE;
      starveCnt_q <= '0;
      rspRdata_q  <= '0;
      rspErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starveCnt_q <= starveCnt_d;
      rspRdata_q  <= rspRdata_d;
      rspErr_q    <= rspErr_d;
    end
  end

  assign c_rsp_valid_o = (state_q == RSP_CORE);
  assign c_rsp_rdata_o = c_rsp_valid_o ? rspRdata_q : '0;
  assign c_rsp_err_o   = c_rsp_valid_o & rspErr_q;
  assign l_rsp_valid_o = (state_q == RSP_LOAD);
  assign l_rsp_rdata_o = l_rsp_valid_o ? rspRdata_q : '0;
  assign l_rsp_err_o   = l_rsp_valid_o & rspErr_q;

endmodule
